btn_event_fsm_ce: RTL and testbench

Button gesture classifier sitting directly downstream of the debounce/one-pulse stage. Consumes the debounced `pressed` level and its `press_pulse`/`release_pulse` strobes and emits one-clock event strobes: short click, double click, long press and auto-repeat while held. All timing runs on the shared 1 kHz `sample_ce` enable in the single `clk` domain. No derived clocks.

---
 rtl/btn_event_fsm_ce.sv | 138 +++++++++++++
 tb/tb_btn_event_fsm_ce.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_event_fsm_ce.sv
// Button gesture classifier: turns debounced press/release strobes into
// registered one-clock click, double-click, long-press and auto-repeat events.
module btn_event_fsm_ce #(
    parameter int CE_HZ      = 1000,
    parameter int LONG_MS    = 800,
    parameter int DBL_MS     = 250,
    parameter int REPEAT_MS  = 150,
    parameter int GEN_REPEAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_ce,
    input  logic pressed,
    input  logic press_pulse,
    input  logic release_pulse,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic long_active
);

    function automatic int ms_to_ticks(input int ms);
        int t;
        t = (ms * CE_HZ + 999) / 1000;
        return (t < 1) ? 1 : t;
    endfunction

    localparam int T_LONG_I = ms_to_ticks(LONG_MS);
    localparam int T_DBL_I  = ms_to_ticks(DBL_MS);
    localparam int T_REP_I  = ms_to_ticks(REPEAT_MS);
    localparam int T_MAX_A  = (T_LONG_I > T_DBL_I) ? T_LONG_I : T_DBL_I;
    localparam int T_MAX    = (T_MAX_A > T_REP_I) ? T_MAX_A : T_REP_I;
    localparam int CNT_W    = $clog2(T_MAX + 1);

    localparam logic [CNT_W-1:0] T_LONG = CNT_W'(T_LONG_I);
    localparam logic [CNT_W-1:0] T_DBL  = CNT_W'(T_DBL_I);
    localparam logic [CNT_W-1:0] T_REP  = CNT_W'(T_REP_I);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic             REP_EN = (GEN_REPEAT != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HELD1,
        S_GAP,
        S_LONG,
        S_WAIT_REL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic             short_d, double_d, long_d, repeat_d;

    assign cnt_nxt = cnt_q + ONE;

    // Strobe inputs take priority over a coincident tick; a lost level aborts silently.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press_pulse) state_d = S_HELD1;
            end
            S_HELD1: begin
                if (release_pulse) begin
                    state_d = S_GAP;
                end else if (!pressed) begin
                    state_d = S_IDLE;
                end else if (sample_ce) begin
                    if (cnt_nxt == T_LONG) begin
                        long_d  = 1'b1;
                        state_d = S_LONG;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            S_GAP: begin
                if (press_pulse) begin
                    double_d = 1'b1;
                    state_d  = S_WAIT_REL;
                end else if (sample_ce) begin
                    if (cnt_nxt == T_DBL) begin
                        short_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            S_LONG: begin
                if (release_pulse || !pressed) begin
                    state_d = S_IDLE;
                end else if (sample_ce) begin
                    if (cnt_nxt == T_REP) begin
                        repeat_d = REP_EN;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            S_WAIT_REL: begin
                if (release_pulse || !pressed) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Each state starts its own timing window from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            short_pulse  <= 1'b0;
            double_pulse <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
            long_active  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            short_pulse  <= short_d;
            double_pulse <= double_d;
            long_pulse   <= long_d;
            repeat_pulse <= repeat_d;
            long_active  <= (state_d == S_LONG);
        end
    end

endmodule

// File: tb/tb_btn_event_fsm_ce.sv
// Scoreboard bench for btn_event_fsm_ce: two instances (repeat on / off) share
// directed stimulus; expected events and levels are queued and checked by a monitor.
module tb_btn_event_fsm_ce;

    localparam logic [3:0] EV_SHORT  = 4'b1000;
    localparam logic [3:0] EV_DOUBLE = 4'b0100;
    localparam logic [3:0] EV_LONG   = 4'b0010;
    localparam logic [3:0] EV_REPEAT = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
    } ev_t;

    typedef struct {
        int   cyc;
        logic la0;
        logic la1;
    } lvl_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sample_ce = 1'b0;
    logic pressed = 1'b0;
    logic press_pulse = 1'b0;
    logic release_pulse = 1'b0;

    logic short0, double0, long0, repeat0, la0;
    logic short1, double1, long1, repeat1, la1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   done = 1'b0;
    ev_t  q0[$];
    ev_t  q1[$];
    lvl_t lq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_event_fsm_ce #(
        .CE_HZ(1000), .LONG_MS(8), .DBL_MS(4), .REPEAT_MS(3), .GEN_REPEAT(1)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_pulse(short0), .double_pulse(double0), .long_pulse(long0),
        .repeat_pulse(repeat0), .long_active(la0)
    );

    btn_event_fsm_ce #(
        .CE_HZ(1000), .LONG_MS(8), .DBL_MS(4), .REPEAT_MS(3), .GEN_REPEAT(0)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_ce(sample_ce), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .short_pulse(short1), .double_pulse(double1), .long_pulse(long1),
        .repeat_pulse(repeat1), .long_active(la1)
    );

    // Monitor: owns all counters; pops expectations as outputs appear.
    always @(negedge clk) begin
        logic [3:0] obs0, obs1;
        ev_t        e;
        lvl_t       l;
        obs0 = {short0, double0, long0, repeat0};
        obs1 = {short1, double1, long1, repeat1};

        if (obs0 != 4'b0 || (q0.size() > 0 && q0[0].cyc <= cyc)) begin
            checks++;
            if (q0.size() == 0 || q0[0].cyc > cyc) begin
                errors++;
                $display("FAIL ev_dut0 cyc %0d got %b expected none", cyc, obs0);
            end else begin
                e = q0.pop_front();
                if (e.cyc != cyc || e.ev != obs0) begin
                    errors++;
                    $display("FAIL ev_dut0 cyc %0d got %b expected %b at cyc %0d",
                             cyc, obs0, e.ev, e.cyc);
                end
            end
        end

        if (obs1 != 4'b0 || (q1.size() > 0 && q1[0].cyc <= cyc)) begin
            checks++;
            if (q1.size() == 0 || q1[0].cyc > cyc) begin
                errors++;
                $display("FAIL ev_dut1 cyc %0d got %b expected none", cyc, obs1);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || e.ev != obs1) begin
                    errors++;
                    $display("FAIL ev_dut1 cyc %0d got %b expected %b at cyc %0d",
                             cyc, obs1, e.ev, e.cyc);
                end
            end
        end

        while (lq.size() > 0 && lq[0].cyc <= cyc) begin
            l = lq.pop_front();
            checks++;
            if (l.cyc != cyc || la0 !== l.la0 || la1 !== l.la1) begin
                errors++;
                $display("FAIL long_active cyc %0d got %b/%b expected %b/%b",
                         cyc, la0, la1, l.la0, l.la1);
            end
        end

        if (done) begin
            checks++;
            if (q0.size() != 0 || q1.size() != 0 || lq.size() != 0) begin
                errors++;
                $display("FAIL leftover got %0d/%0d/%0d pending expected 0/0/0",
                         q0.size(), q1.size(), lq.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic step(input logic ce, input logic pp, input logic rp);
        sample_ce     = ce;
        press_pulse   = pp;
        release_pulse = rp;
        @(posedge clk);
        #1;
        sample_ce     = 1'b0;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
    endtask

    // n ticks of sample_ce, one every 4 clk; returns just after the last tick edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic expect_ev(input logic [3:0] ev, input bit both);
        q0.push_back('{cyc: cyc, ev: ev});
        if (both) q1.push_back('{cyc: cyc, ev: ev});
    endtask

    task automatic expect_la(input logic a, input logic b);
        lq.push_back('{cyc: cyc, la0: a, la1: b});
    endtask

    task automatic press;
        pressed = 1'b1;
        step(1'b0, 1'b1, 1'b0);
    endtask

    task automatic release_btn;
        pressed = 1'b0;
        step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        expect_la(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Single click: short 4 ticks after release.
        press();
        tick(3);
        expect_la(1'b0, 1'b0);
        release_btn();
        tick(4);
        expect_ev(EV_SHORT, 1'b1);
        tick(3);

        // Double click, then a fresh single click after release.
        press();
        tick(2);
        release_btn();
        tick(2);
        press();
        expect_ev(EV_DOUBLE, 1'b1);
        tick(2);
        release_btn();
        tick(1);
        press();
        tick(1);
        release_btn();
        tick(4);
        expect_ev(EV_SHORT, 1'b1);
        tick(2);

        // Long press held 15 ticks with auto-repeat.
        press();
        tick(7);
        expect_la(1'b0, 1'b0);
        tick(1);
        expect_ev(EV_LONG, 1'b1);
        expect_la(1'b1, 1'b1);
        tick(3);
        expect_ev(EV_REPEAT, 1'b0);
        tick(3);
        expect_ev(EV_REPEAT, 1'b0);
        tick(1);
        expect_la(1'b1, 1'b1);
        release_btn();
        expect_la(1'b0, 1'b0);
        tick(3);

        // Release coincident with the 8th tick: no long, then short.
        press();
        tick(7);
        pressed = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        expect_la(1'b0, 1'b0);
        tick(4);
        expect_ev(EV_SHORT, 1'b1);
        tick(2);

        // Gap of exactly 4 ticks: short, and the next press is a new gesture.
        press();
        tick(2);
        release_btn();
        tick(4);
        expect_ev(EV_SHORT, 1'b1);
        press();
        tick(2);
        release_btn();
        tick(4);
        expect_ev(EV_SHORT, 1'b1);
        tick(1);

        // Level drops in LONG without a release strobe: silent abort.
        press();
        tick(8);
        expect_ev(EV_LONG, 1'b1);
        tick(1);
        pressed = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        expect_la(1'b0, 1'b0);
        tick(6);

        // Reset during HELD1: nothing after deassertion without a new press.
        press();
        tick(3);
        rst_n = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        expect_la(1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        tick(10);
        release_btn();
        tick(5);

        // Asynchronous reset in LONG clears long_active within the cycle.
        press();
        tick(8);
        expect_ev(EV_LONG, 1'b1);
        tick(1);
        rst_n = 1'b0;
        expect_la(1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        tick(4);
        release_btn();
        tick(3);

        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
